// File: rtl/gate_eval_pkg.sv
// Shared types and the gate evaluation function for gate_eval_arbiter.
//   op_e     : 3-bit opcode encoding (AND..INV, 7 reserved)
//   state_e  : arbiter FSM states
//   ge_res_t : evaluation result (GE_MAX_W-bit y plus reserved-opcode flag)
//   eval_gate: bitwise evaluation on GE_MAX_W-wide operands; callers
//              zero-extend their operands and keep the low WIDTH bits.
package gate_eval_pkg;

  localparam int GE_MAX_W = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_NAND = 3'd1,
    OP_OR   = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_INV  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [GE_MAX_W-1:0] y;
    logic                err;
  } ge_res_t;

  function automatic ge_res_t eval_gate(op_e op, logic [GE_MAX_W-1:0] a,
                                        logic [GE_MAX_W-1:0] b);
    ge_res_t r;
    r.y   = '0;
    r.err = 1'b0;
    case (op)
      OP_AND:  r.y = a & b;
      OP_NAND: r.y = ~(a & b);
      OP_OR:   r.y = a | b;
      OP_NOR:  r.y = ~(a | b);
      OP_XOR:  r.y = a ^ b;
      OP_XNOR: r.y = ~(a ^ b);
      OP_INV:  r.y = ~a;
      default: r.err = 1'b1;  // reserved: y stays zero
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_eval_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : highest-priority index (must be < N)
//   win : one-hot winner (zero when no request)
//   idx : winner index (zero when no request)
// The search starts at ptr and wraps, taking the first set request.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so a single subtraction completes the wrap
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        win[pos[IW-1:0]]     = 1'b1;
        idx                  = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gate_eval_arbiter.sv
// Shares one logic evaluation unit among N requesters.
//   clk, rst_n : clock, async active-low reset
//   req[N]     : request levels
//   op[3N]     : opcodes, requester i at [3i+2:3i]
//   a, b[W*N]  : operands, requester i at [W*i +: W]
//   gnt[N]     : one-hot grant, capture through done
//   done[N]    : one-hot one-cycle completion pulse
//   y[W]       : result, updated on DONE entry and held
//   err        : reserved-opcode flag, pulsed with done
// A grant captures the winner's operands; EVAL lasts DELAY cycles to model
// propagation delay, then DONE pulses for one cycle and the pointer advances.
module gate_eval_arbiter
  import gate_eval_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int DELAY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req,
  input  logic [3*N-1:0]     op,
  input  logic [WIDTH*N-1:0] a,
  input  logic [WIDTH*N-1:0] b,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       done,
  output logic [WIDTH-1:0]   y,
  output logic               err
);

  localparam int IW = $clog2(N);
  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

  if (N < 2 || N > 16 || DELAY < 1 || WIDTH < 1 || WIDTH > GE_MAX_W) begin : g_bad_param
    $error("gate_eval_arbiter: illegal parameters N=%0d WIDTH=%0d DELAY=%0d",
           N, WIDTH, DELAY);
  end

  // per-requester views of the flat buses
  logic [N-1:0][2:0]       op_v;
  logic [N-1:0][WIDTH-1:0] a_v, b_v;
  assign op_v = op;
  assign a_v  = a;
  assign b_v  = b;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   ptr_q, win_q;
  logic [N-1:0]    gnt_q;
  op_e             op_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic            err_q;

  logic [N-1:0]    arb_win;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .win (arb_win),
    .idx (arb_idx)
  );

  ge_res_t             res;
  logic [GE_MAX_W-1:0] y_wide_unused;  // bits above WIDTH are don't-care
  always_comb res = eval_gate(op_q, GE_MAX_W'(a_q), GE_MAX_W'(b_q));
  assign y_wide_unused = res.y;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = EVAL;
      EVAL:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs: done/err are qualified by DONE so they are single-cycle pulses
  always_comb begin
    done = (state_q == DONE) ? gnt_q : '0;
    err  = (state_q == DONE) && err_q;
  end

  assign gnt = gnt_q;
  assign y   = y_q;

  // datapath: capture, countdown, result register, pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ptr_q <= '0;
      win_q <= '0;
      gnt_q <= '0;
      op_q  <= OP_AND;
      a_q   <= '0;
      b_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          win_q <= arb_idx;
          gnt_q <= arb_win;
          op_q  <= op_e'(op_v[arb_idx]);
          a_q   <= a_v[arb_idx];
          b_q   <= b_v[arb_idx];
          cnt_q <= CW'(DELAY - 1);
        end
        EVAL: begin
          if (cnt_q == '0) begin
            y_q   <= y_wide_unused[WIDTH-1:0];
            err_q <= res.err;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          gnt_q <= '0;
          ptr_q <= (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
        end
        default: gnt_q <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench for gate_eval_arbiter (N=4, WIDTH=4, DELAY=2).
// Stimulus pushes expected {done, y, err} into a scoreboard queue; a monitor
// on the falling edge pops and compares whenever done is asserted.
module tb_gate_eval_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [3*N-1:0] op = '0;
  logic [W*N-1:0] a = '0;
  logic [W*N-1:0] b = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   y;
  logic           err;

  gate_eval_arbiter #(.N(N), .WIDTH(W), .DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
    .gnt(gnt), .done(done), .y(y), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] done;
    logic [W-1:0] y;
    logic         err;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(logic [N-1:0] d, logic [W-1:0] yy, logic ee);
    exp_t x;
    x.done = d; x.y = yy; x.err = ee;
    sb.push_back(x);
  endtask

  // step to 1 time unit after the next n rising edges
  task automatic adv(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_rq(int i, logic [2:0] o, logic [W-1:0] av, logic [W-1:0] bv);
    op[3*i +: 3] = o;
    a[W*i +: W]  = av;
    b[W*i +: W]  = bv;
  endtask

  // ends at the start of "cycle 0", ready to drive
  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    adv(2);
    rst_n = 1'b1;
    adv(1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(gnt) > 1 || $countones(done) > 1) begin
        errors++;
        $display("FAIL onehot: gnt=%b done=%b", gnt, done);
      end
      if (done != '0) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: done=%b y=%b err=%b, none expected", done, y, err);
        end else begin
          e = sb.pop_front();
          chk("sb_done", done, e.done);
          chk("sb_y", y, e.y);
          chk("sb_err", {3'b000, err}, {3'b000, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    adv(1);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_y", y, 4'b0000);
    chk("rst_err", {3'b000, err}, 4'b0000);

    // 1: single request, AND
    do_reset();
    set_rq(0, 3'd0, 4'b1100, 4'b1010);
    req = 4'b0001;
    push(4'b0001, 4'b1000, 1'b0);
    chk("t1_gnt_c0", gnt, 4'b0000);
    adv(1); req = '0;
    chk("t1_gnt_c1", gnt, 4'b0001);
    adv(1);
    chk("t1_gnt_c2", gnt, 4'b0001);
    chk("t1_done_c2", done, 4'b0000);
    adv(1);
    chk("t1_gnt_c3", gnt, 4'b0001);
    chk("t1_done_c3", done, 4'b0001);
    chk("t1_y_c3", y, 4'b1000);
    adv(1);
    chk("t1_gnt_c4", gnt, 4'b0000);
    chk("t1_done_c4", done, 4'b0000);
    adv(6);
    chk("t1_y_c10", y, 4'b1000);

    // 2: all four at once, served 0,1,2,3
    do_reset();
    set_rq(0, 3'd1, 4'b0110, 4'b0011);
    set_rq(1, 3'd2, 4'b0110, 4'b0011);
    set_rq(2, 3'd4, 4'b0110, 4'b0011);
    set_rq(3, 3'd6, 4'b0110, 4'b0011);
    req = 4'b1111;
    push(4'b0001, 4'b1101, 1'b0);
    push(4'b0010, 4'b0111, 1'b0);
    push(4'b0100, 4'b0101, 1'b0);
    push(4'b1000, 4'b1001, 1'b0);
    adv(3);
    chk("t2_done_c3", done, 4'b0001);
    adv(4);
    chk("t2_done_c7", done, 4'b0010);
    adv(4);
    chk("t2_done_c11", done, 4'b0100);
    adv(4);
    chk("t2_done_c15", done, 4'b1000);
    adv(1); req = '0;
    adv(3);
    chk("t2_idle", gnt, 4'b0000);

    // 3: fairness between 0 and 2
    do_reset();
    set_rq(0, 3'd0, 4'b1111, 4'b0011);
    set_rq(2, 3'd2, 4'b0001, 4'b0100);
    req = 4'b0101;
    push(4'b0001, 4'b0011, 1'b0);
    push(4'b0100, 4'b0101, 1'b0);
    push(4'b0001, 4'b0011, 1'b0);
    push(4'b0100, 4'b0101, 1'b0);
    adv(1);
    chk("t3_gnt_c1", gnt, 4'b0001);
    adv(4);
    chk("t3_gnt_c5", gnt, 4'b0100);
    adv(4);
    chk("t3_gnt_c9", gnt, 4'b0001);
    adv(4);
    chk("t3_gnt_c13", gnt, 4'b0100);
    adv(3); req = '0;
    adv(3);

    // 4: reserved opcode, then operands changed during EVAL
    do_reset();
    set_rq(1, 3'd7, 4'b1010, 4'b0101);
    req = 4'b0010;
    push(4'b0010, 4'b0000, 1'b1);
    adv(1); req = '0;
    adv(2);
    chk("t4_err_c3", {3'b000, err}, 4'b0001);
    chk("t4_y_c3", y, 4'b0000);
    adv(1);
    chk("t4_err_c4", {3'b000, err}, 4'b0000);
    set_rq(1, 3'd5, 4'b1111, 4'b0000);
    req = 4'b0010;
    push(4'b0010, 4'b0000, 1'b0);
    adv(2);
    a[W*1 +: W] = 4'b0000;
    req = '0;
    adv(1);
    chk("t4_done_late", done, 4'b0010);
    chk("t4_y_late", y, 4'b0000);
    adv(2);

    // 5: reset in the middle of EVAL
    do_reset();
    set_rq(1, 3'd2, 4'b1111, 4'b0000);
    req = 4'b0010;
    push(4'b0010, 4'b1111, 1'b0);
    adv(1); req = '0;
    adv(3);
    set_rq(1, 3'd0, 4'b1010, 4'b1010);
    req = 4'b0010;
    adv(1); req = '0;
    chk("t5_gnt_eval", gnt, 4'b0010);
    adv(1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_gnt", gnt, 4'b0000);
    chk("t5_async_done", done, 4'b0000);
    chk("t5_async_err", {3'b000, err}, 4'b0000);
    chk("t5_async_y", y, 4'b0000);
    adv(2);
    rst_n = 1'b1;
    adv(1);
    set_rq(1, 3'd0, 4'b0110, 4'b1100);
    set_rq(2, 3'd4, 4'b0110, 4'b1100);
    req = 4'b0110;
    push(4'b0010, 4'b0100, 1'b0);
    push(4'b0100, 4'b1010, 1'b0);
    adv(1);
    chk("t5_first_gnt", gnt, 4'b0010);
    adv(4);
    chk("t5_second_gnt", gnt, 4'b0100);
    req = '0;
    adv(5);

    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
